pair_triple_event_counter: RTL and testbench

//  Downstream consumer of the pair/triple (2-of-3 majority) detector output.

---
 rtl/pair_triple_event_counter.sv | 165 ++++++++++++++++
 tb/tb_pair_triple_event_counter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pair_triple_event_counter.sv
// pair_triple_event_counter
// Takes the raw 2-of-3 majority detector bit, which is asynchronous to clk.
// It synchronises the bit, debounces it with a four-state FSM, and counts
// accepted rising events in a saturating counter.
// Every output comes from a register or from decoding the state register, so
// no input has a combinational path to any output.

module pair_triple_event_counter #(
  parameter int DEBOUNCE_CYCLES = 4,  // identical synced samples to accept a change, >= 1
  parameter int COUNT_WIDTH     = 8   // event_count width; saturates at all-ones
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   det,
  input  logic                   clear,
  output logic                   det_stable,
  output logic                   event_pulse,
  output logic [COUNT_WIDTH-1:0] event_count,
  output logic                   saturated
);

  // The run counter only has to reach DEBOUNCE_CYCLES-1. Sizing it for
  // DEBOUNCE_CYCLES keeps the width legal when DEBOUNCE_CYCLES is 1.
  localparam int RUN_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [RUN_WIDTH-1:0]   RUN_LAST  = RUN_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [RUN_WIDTH-1:0]   RUN_ONE   = RUN_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  // S_LOW / S_HIGH are the settled levels.
  // S_RISE / S_FALL are qualifying a candidate change of level.
  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  logic                   s1;
  logic                   det_s;
  state_t                 state;
  state_t                 next_state;
  logic [RUN_WIDTH-1:0]   run;
  logic [RUN_WIDTH-1:0]   next_run;
  logic                   accept;
  logic [COUNT_WIDTH-1:0] count_inc;

  // Two-flop synchroniser. Only det_s is allowed into the FSM.
  // NOTE: sequential state is updated with non-blocking assignments so that
  // every flop samples its pre-edge inputs, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      det_s <= 1'b0;
    end else begin
      s1    <= det;
      det_s <= s1;
    end
  end

  // State register and run counter for the debounce FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOW;
      run   <= '0;
    end else begin
      state <= next_state;
      run   <= next_run;
    end
  end

  // Next-state logic. The run counter counts how many consecutive synced
  // samples have agreed with the candidate level. It is 0 in the settled
  // states.
  // NOTE: every variable written here gets a default value first, so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    next_state = state;
    next_run   = run;
    accept     = 1'b0;
    unique case (state)
      S_LOW: begin
        if (det_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            next_state = S_HIGH;
            next_run   = '0;
            accept     = 1'b1;
          end else begin
            next_state = S_RISE;
            next_run   = RUN_ONE;
          end
        end
      end
      S_RISE: begin
        if (!det_s) begin
          next_state = S_LOW;
          next_run   = '0;
        end else if (run == RUN_LAST) begin
          next_state = S_HIGH;
          next_run   = '0;
          accept     = 1'b1;
        end else begin
          next_run   = run + RUN_ONE;
        end
      end
      S_HIGH: begin
        if (!det_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            next_state = S_LOW;
            next_run   = '0;
          end else begin
            next_state = S_FALL;
            next_run   = RUN_ONE;
          end
        end
      end
      S_FALL: begin
        if (det_s) begin
          // A bounce back up returns to the settled high level.
          // It is not a new event.
          next_state = S_HIGH;
          next_run   = '0;
        end else if (run == RUN_LAST) begin
          next_state = S_LOW;
          next_run   = '0;
        end else begin
          next_run   = run + RUN_ONE;
        end
      end
      default: begin
        next_state = S_LOW;
        next_run   = '0;
      end
    endcase
  end

  // The debounced level is a pure decode of the state register.
  // S_FALL still reports high until the fall has been qualified.
  assign det_stable = (state == S_HIGH) || (state == S_FALL);

  // Saturating increment.
  // saturated then follows from the value being written.
  assign count_inc = (event_count == COUNT_MAX) ? event_count : event_count + 1'b1;

  // Event pulse and counter.
  // clear wins over a coincident accept for the count, but the pulse still
  // fires so that downstream logic sees the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_pulse <= 1'b0;
      event_count <= '0;
      saturated   <= 1'b0;
    end else begin
      event_pulse <= accept;
      if (clear) begin
        event_count <= '0;
        saturated   <= 1'b0;
      end else if (accept) begin
        event_count <= count_inc;
        saturated   <= (count_inc == COUNT_MAX);
      end
    end
  end

endmodule

// File: tb/tb_pair_triple_event_counter.sv
// tb_pair_triple_event_counter
// Three instances share one stimulus stream:
//   u0: DEBOUNCE_CYCLES=4, COUNT_WIDTH=8 (default)
//   u1: DEBOUNCE_CYCLES=4, COUNT_WIDTH=2 (saturation)
//   u2: DEBOUNCE_CYCLES=1, COUNT_WIDTH=8 (minimum debounce)
// The reference model tracks how many consecutive observed samples disagree
// with the settled level, and flips the level once that run reaches the
// debounce length.

module tb_pair_triple_event_counter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic det   = 1'b0;
  logic clear = 1'b0;

  logic [2:0] stable;
  logic [2:0] pulse;
  logic [2:0] sat;
  logic [7:0] cnt0;
  logic [1:0] cnt_sat;
  logic [7:0] cnt2;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pair_triple_event_counter #(.DEBOUNCE_CYCLES(4), .COUNT_WIDTH(8)) u0 (
    .clk(clk), .rst_n(rst_n), .det(det), .clear(clear),
    .det_stable(stable[0]), .event_pulse(pulse[0]),
    .event_count(cnt0), .saturated(sat[0])
  );

  pair_triple_event_counter #(.DEBOUNCE_CYCLES(4), .COUNT_WIDTH(2)) u1 (
    .clk(clk), .rst_n(rst_n), .det(det), .clear(clear),
    .det_stable(stable[1]), .event_pulse(pulse[1]),
    .event_count(cnt_sat), .saturated(sat[1])
  );

  pair_triple_event_counter #(.DEBOUNCE_CYCLES(1), .COUNT_WIDTH(8)) u2 (
    .clk(clk), .rst_n(rst_n), .det(det), .clear(clear),
    .det_stable(stable[2]), .event_pulse(pulse[2]),
    .event_count(cnt2), .saturated(sat[2])
  );

  // Reference model, one slot per instance.
  int d_tab   [3] = '{4, 4, 1};
  int max_tab [3] = '{255, 3, 255};
  int m_s1 [3];
  int m_s2 [3];
  int m_stable [3];
  int m_run [3];
  int m_pulse [3];
  int m_count [3];
  int m_sat [3];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_stable[i] = 0; m_run[i] = 0;
      m_pulse[i] = 0; m_count[i] = 0; m_sat[i] = 0;
    end
  endfunction

  // One rising edge, evaluated on the pre-edge inputs.
  function automatic void model_edge();
    int obs;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_s1[i] = 0; m_s2[i] = 0; m_stable[i] = 0; m_run[i] = 0;
        m_pulse[i] = 0; m_count[i] = 0; m_sat[i] = 0;
      end else begin
        obs = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = int'(det);
        m_pulse[i] = 0;
        // Count consecutive samples that disagree with the settled level.
        if (obs != m_stable[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == d_tab[i]) begin
          m_run[i] = 0;
          m_stable[i] = 1 - m_stable[i];
          if (m_stable[i] == 1) begin
            m_pulse[i] = 1;
            if (!clear) begin
              if (m_count[i] < max_tab[i]) m_count[i]++;
              m_sat[i] = (m_count[i] == max_tab[i]) ? 1 : 0;
            end
          end
        end
        if (clear) begin
          m_count[i] = 0;
          m_sat[i] = 0;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] get_count(input int i);
    case (i)
      0:       return 32'(cnt0);
      1:       return 32'(cnt_sat);
      default: return 32'(cnt2);
    endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d det_stable", i), 32'(stable[i]), m_stable[i]);
      check($sformatf("u%0d event_pulse", i), 32'(pulse[i]), m_pulse[i]);
      check($sformatf("u%0d event_count", i), get_count(i), m_count[i]);
      check($sformatf("u%0d saturated", i), 32'(sat[i]), m_sat[i]);
    end
  endtask

  // Drive at the falling edge, advance the model at the rising edge, and
  // sample 1 time unit after the rising edge.
  task automatic step(input logic d, input logic c, input logic r);
    @(negedge clk);
    det = d; clear = c; rst_n = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Assert reset between clock edges and check before the next edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
  endtask

  int pulses_sat;
  int v;
  int len;

  initial begin
    // Reset from power-up, with no clock edge yet.
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    step(0, 0, 0);
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1);

    // Clean rise: det first sampled high at edge 0.
    // Accept at edge 5, then release.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1);
      check("t2 pulse", 32'(pulse[0]), (i == 5) ? 1 : 0);
    end
    check("t2 count", 32'(cnt0), 1);
    for (int j = 0; j < 10; j++) begin
      step(0, 0, 1);
      check("t2 stable on fall", 32'(stable[0]), (j < 5) ? 1 : 0);
    end

    // Bounce pattern never reaches four consecutive highs.
    begin
      logic [7:0] bounce;
      bounce = 8'b0111_0111;
      for (int i = 0; i < 8; i++) begin
        step(bounce[7-i], 0, 1);
        check("t3 pulse", 32'(pulse[0]), 0);
      end
      for (int i = 0; i < 6; i++) begin
        step(0, 0, 1);
        check("t3 pulse tail", 32'(pulse[0]), 0);
        check("t3 stable", 32'(stable[0]), 0);
      end
      check("t3 count", 32'(cnt0), 1);
    end

    // Five clean events into the 2-bit counter.
    step(0, 1, 1);
    check("clear count", 32'(cnt0), 0);
    pulses_sat = 0;
    for (int n = 1; n <= 5; n++) begin
      for (int i = 0; i < 8; i++) begin
        step(1, 0, 1);
        if (pulse[1]) pulses_sat++;
      end
      check("t4 sat count", 32'(cnt_sat), (n < 3) ? n : 3);
      check("t4 saturated", 32'(sat[1]), (n >= 3) ? 1 : 0);
      for (int i = 0; i < 8; i++) step(0, 0, 1);
    end
    check("t4 pulses", pulses_sat, 5);
    check("t4 u0 count", 32'(cnt0), 5);

    // Bring u0 to 7, then assert clear on the accepting edge.
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 8; i++) step(1, 0, 1);
      for (int i = 0; i < 8; i++) step(0, 0, 1);
    end
    check("t5 pre count", 32'(cnt0), 7);
    for (int i = 0; i < 10; i++) begin
      step(1, (i == 5) ? 1'b1 : 1'b0, 1);
      if (i == 5) begin
        check("t5 pulse", 32'(pulse[0]), 1);
        check("t5 count", 32'(cnt0), 0);
        check("t5 saturated", 32'(sat[1]), 0);
      end
    end
    for (int i = 0; i < 10; i++) step(0, 0, 1);
    step(0, 1, 1);
    check("t5 idle clear", 32'(cnt0), 0);

    // Reach S_HIGH with count 5, then reset mid-cycle while det is held high.
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 8; i++) step(1, 0, 1);
      for (int i = 0; i < 8; i++) step(0, 0, 1);
    end
    for (int i = 0; i < 8; i++) step(1, 0, 1);
    check("t1 pre count", 32'(cnt0), 5);
    check("t1 pre stable", 32'(stable[0]), 1);
    async_reset();
    check("t1 count", 32'(cnt0), 0);
    check("t1 stable", 32'(stable[0]), 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("t6 in reset", 32'(cnt0), 0);
    for (int e = 1; e <= 8; e++) begin
      step(1, 0, 1);
      check("t6 pulse", 32'(pulse[0]), (e == 6) ? 1 : 0);
      if (e >= 6) check("t6 count", 32'(cnt0), 1);
    end

    // Randomised bursts, with occasional clears and resets.
    for (int b = 0; b < 60; b++) begin
      v = $urandom_range(0, 1);
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 19) == 0) begin
        async_reset();
        step(v[0], 0, 0);
      end
      for (int i = 0; i < len; i++)
        step(v[0], ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
